// File: rtl/resp_framer_pkg.sv
// Shared definitions for the response framer and the command decoder:
// line terminators, command opcodes and the framer state encoding.
package resp_framer_pkg;

  localparam logic [7:0] CR = 8'h0d;
  localparam logic [7:0] NL = 8'h0a;

  typedef enum logic [7:0] {
    CMD_STATE0    = 8'd0,
    CMD_PER       = 8'd1,
    CMD_ED        = 8'd2,
    CMD_OUTER_PER = 8'd3,
    CMD_PRINT     = 8'd4,
    CMD_CLEAR     = 8'd5
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND      = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_IDLE = 3'd3,
    ST_FIN       = 3'd4
  } state_t;

endpackage

// File: rtl/resp_framer_if.sv
// Bundle between the framer, its requester and the UART transmitter.
interface resp_framer_if #(
  parameter int BYTES = 16
);
  localparam int LW = $clog2(BYTES + 1);

  // Handshakes: start is a one-cycle request that is only taken while busy is
  // low; busy then stays high until the done or err pulse. Toward the UART,
  // transmit is a one-cycle pulse issued only while is_transmitting is low,
  // and the UART acknowledges by raising is_transmitting until the byte is out.
  logic                 start;
  logic [7:0]           opcode;
  logic [LW-1:0]        len;
  logic [8*BYTES-1:0]   payload;
  logic                 is_transmitting;
  logic                 transmit;
  logic [7:0]           tx_byte;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    output start, opcode, len, payload, is_transmitting,
    input  transmit, tx_byte, busy, done, err
  );

  modport slave (
    input  start, opcode, len, payload, is_transmitting,
    output transmit, tx_byte, busy, done, err
  );

endinterface

// File: rtl/resp_framer.sv
// Sends opcode, payload[0..len-1], CR, NL to a byte UART, one byte per
// transmit pulse, and aborts the frame if the UART never acknowledges.
module resp_framer
  import resp_framer_pkg::*;
#(
  parameter int BYTES       = 16,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  resp_framer_if.slave  bus,
  output state_t        dbg_state
);

  localparam int LW = $clog2(BYTES + 1);
  localparam int IW = $clog2(BYTES + 3);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [LW-1:0] LEN_MAX  = LW'(BYTES);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [7:0]         opcode_q, opcode_d;
  logic [LW-1:0]      len_q, len_d;
  logic [8*BYTES-1:0] payload_q, payload_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               transmit_q, transmit_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [7:0]         cur_byte;
  logic [IW-1:0]      last_idx;
  logic               last_byte;

  assign last_idx  = IW'(len_q) + IW'(2);
  assign last_byte = (idx_q == last_idx);

  // Frame byte at idx_q: 0 is the opcode, 1..len the payload, then CR, NL.
  always_comb begin
    cur_byte = NL;
    if (idx_q == '0) begin
      cur_byte = opcode_q;
    end else if (idx_q <= IW'(len_q)) begin
      for (int k = 0; k < BYTES; k++) begin
        if (idx_q == IW'(k + 1)) cur_byte = payload_q[8*k +: 8];
      end
    end else if (idx_q == IW'(len_q) + IW'(1)) begin
      cur_byte = CR;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      opcode_q   <= '0;
      len_q      <= '0;
      payload_q  <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      transmit_q <= 1'b0;
      tx_byte_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      len_q      <= len_d;
      payload_q  <= payload_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      transmit_q <= transmit_d;
      tx_byte_q  <= tx_byte_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (bus.start) state_d = ST_SEND;
      ST_SEND:      if (!bus.is_transmitting) state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (bus.is_transmitting)   state_d = ST_WAIT_IDLE;
        else if (cnt_q == CNT_LAST) state_d = ST_IDLE;
      end
      ST_WAIT_IDLE: if (!bus.is_transmitting) state_d = last_byte ? ST_FIN : ST_SEND;
      ST_FIN:       state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    opcode_d   = opcode_q;
    len_d      = len_q;
    payload_d  = payload_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    transmit_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          opcode_d  = bus.opcode;
          len_d     = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;
          payload_d = bus.payload;
          idx_d     = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
        end
      end
      ST_SEND: begin
        if (!bus.is_transmitting) begin
          transmit_d = 1'b1;
          tx_byte_d  = cur_byte;
          cnt_d      = '0;
        end
      end
      ST_WAIT_BUSY: begin
        // The counter only runs while the UART has not yet acknowledged.
        if (bus.is_transmitting) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          err_d  = 1'b1;
          busy_d = 1'b0;
          cnt_d  = '0;
          idx_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        if (!bus.is_transmitting) idx_d = idx_q + 1'b1;
      end
      ST_FIN: begin
        done_d = 1'b1;
        busy_d = 1'b0;
        idx_d  = '0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign bus.transmit = transmit_q;
  assign bus.tx_byte  = tx_byte_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_resp_framer.sv
// Scoreboard bench for resp_framer: a behavioural UART answers transmit
// pulses and every transmitted byte is popped against the expected frame.
module tb_resp_framer;
  import resp_framer_pkg::*;

  localparam int BYTES       = 16;
  localparam int ACK_TIMEOUT = 16;
  localparam int LW          = $clog2(BYTES + 1);

  logic   sys_clk = 1'b0;
  logic   rst_n   = 1'b0;
  logic   is_tx   = 1'b0;
  state_t dbg_state;

  resp_framer_if #(.BYTES(BYTES)) bus();

  resp_framer #(.BYTES(BYTES), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  assign bus.is_transmitting = is_tx;

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int tx_cnt   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  bit uart_stuck_high = 1'b0;
  bit uart_dead       = 1'b0;
  bit rise_pend       = 1'b0;
  int hold            = 0;

  // ---------------- clock ----------------
  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_transmit"}, 32'(bus.transmit), 32'd0);
    check({tag, "_tx_byte"},  32'(bus.tx_byte),  32'd0);
    check({tag, "_busy"},     32'(bus.busy),     32'd0);
    check({tag, "_done"},     32'(bus.done),     32'd0);
    check({tag, "_err"},      32'(bus.err),      32'd0);
    check({tag, "_state"},    32'(dbg_state),    32'(ST_IDLE));
  endtask

  // ---------------- UART model ----------------
  // Raises is_transmitting one cycle after a transmit pulse, holds 10 cycles.
  always @(posedge sys_clk) begin
    #1;
    if (uart_stuck_high) begin
      is_tx = 1'b1; hold = 0; rise_pend = 1'b0;
    end else if (uart_dead) begin
      is_tx = 1'b0; hold = 0; rise_pend = 1'b0;
    end else if (rise_pend) begin
      is_tx = 1'b1; hold = 9; rise_pend = 1'b0;
    end else if (hold > 0) begin
      hold--;
    end else begin
      is_tx = 1'b0;
    end
    if (!uart_stuck_high && !uart_dead && bus.transmit) rise_pend = 1'b1;
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge sys_clk) begin
    logic [7:0] exp_b;
    if (rst_n && bus.transmit) begin
      tx_cnt++;
      if (exp_q.size() == 0) begin
        check("tx_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_b = exp_q.pop_front();
        check("tx_byte", 32'(bus.tx_byte), 32'(exp_b));
      end
    end
    if (bus.done) done_cnt++;
    if (bus.err)  err_cnt++;
    if (bus.done || bus.err) check("done_err_excl", 32'(bus.done & bus.err), 32'd0);
  end

  // ---------------- drivers ----------------
  task automatic push_frame(input logic [7:0] op, input logic [LW-1:0] ln, input logic [8*BYTES-1:0] pl);
    int n;
    n = (int'(ln) > BYTES) ? BYTES : int'(ln);
    exp_q.push_back(op);
    for (int k = 0; k < n; k++) exp_q.push_back(pl[8*k +: 8]);
    exp_q.push_back(8'h0d);
    exp_q.push_back(8'h0a);
  endtask

  task automatic drive_start(input logic [7:0] op, input logic [LW-1:0] ln,
                             input logic [8*BYTES-1:0] pl, input bit expect_frame);
    @(posedge sys_clk); #1;
    bus.start   = 1'b1;
    bus.opcode  = op;
    bus.len     = ln;
    bus.payload = pl;
    if (expect_frame) push_frame(op, ln, pl);
    @(posedge sys_clk); #1;
    bus.start = 1'b0;
  endtask

  function automatic logic [8*BYTES-1:0] rand_payload();
    logic [8*BYTES-1:0] pl;
    for (int k = 0; k < BYTES; k++) pl[8*k +: 8] = 8'($urandom_range(0, 255));
    return pl;
  endfunction

  task automatic wait_end(input string tag, input int d0, input int e0, input int budget);
    int n;
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    @(negedge sys_clk);
    check({tag, "_end_pulse"}, 32'(done_cnt - d0 + err_cnt - e0), 32'd1);
  endtask

  task automatic frame_check(input string tag, input int t0, input int d0, input int e0,
                             input int ntx, input int ndone, input int nerr);
    check({tag, "_tx_count"}, 32'(tx_cnt - t0),   32'(ntx));
    check({tag, "_done"},     32'(done_cnt - d0), 32'(ndone));
    check({tag, "_err"},      32'(err_cnt - e0),  32'(nerr));
    check({tag, "_busy_low"}, 32'(bus.busy),      32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int t0, d0, e0, n, d;
    logic [8*BYTES-1:0] pl;

    bus.start = 1'b0; bus.opcode = '0; bus.len = '0; bus.payload = '0;

    rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_idle_outputs("reset");
    @(posedge sys_clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // basic frame plus start-to-transmit latency
    t0 = tx_cnt; d0 = done_cnt; e0 = err_cnt;
    drive_start(8'h04, LW'(2), {112'd0, 8'hBE, 8'hEF}, 1'b1);
    @(negedge sys_clk);
    check("lat_busy", 32'(bus.busy), 32'd1);
    check("lat_no_tx_yet", 32'(bus.transmit), 32'd0);
    @(negedge sys_clk);
    check("lat_tx", 32'(bus.transmit), 32'd1);
    wait_end("basic", d0, e0, 600);
    @(negedge sys_clk);
    frame_check("basic", t0, d0, e0, 5, 1, 0);
    check("basic_queue", 32'(exp_q.size()), 32'd0);

    // empty payload
    t0 = tx_cnt; d0 = done_cnt; e0 = err_cnt;
    drive_start(CMD_PER, LW'(0), rand_payload(), 1'b1);
    wait_end("len0", d0, e0, 400);
    @(negedge sys_clk);
    frame_check("len0", t0, d0, e0, 3, 1, 0);

    // UART busy when start arrives
    @(negedge sys_clk); uart_stuck_high = 1'b1;
    repeat (3) @(negedge sys_clk);
    t0 = tx_cnt; d0 = done_cnt; e0 = err_cnt;
    drive_start(CMD_ED, LW'(1), rand_payload(), 1'b1);
    repeat (6) @(negedge sys_clk);
    check("stuck_no_tx", 32'(tx_cnt - t0), 32'd0);
    check("stuck_state", 32'(dbg_state), 32'(ST_SEND));
    uart_stuck_high = 1'b0;
    @(negedge sys_clk);
    check("stuck_fall_no_tx", 32'(bus.transmit), 32'd0);
    @(negedge sys_clk);
    check("stuck_first_tx", 32'(bus.transmit), 32'd1);
    wait_end("stuck", d0, e0, 400);
    @(negedge sys_clk);
    frame_check("stuck", t0, d0, e0, 4, 1, 0);

    // UART never acknowledges: timeout
    @(negedge sys_clk); uart_dead = 1'b1;
    t0 = tx_cnt; d0 = done_cnt; e0 = err_cnt;
    drive_start(CMD_STATE0, LW'(3), rand_payload(), 1'b1);
    n = 0;
    while (!bus.transmit && n < 10) begin @(negedge sys_clk); n++; end
    check("tmo_first_tx", 32'(bus.transmit), 32'd1);
    d = 0;
    do begin @(negedge sys_clk); d++; end while (!bus.err && d < 40);
    check("tmo_err_latency", 32'(d), 32'(ACK_TIMEOUT));
    check("tmo_busy_at_err", 32'(bus.busy), 32'd0);
    repeat (20) @(negedge sys_clk);
    frame_check("tmo", t0, d0, e0, 1, 0, 1);
    exp_q.delete();
    uart_dead = 1'b0;

    // clamped length and an ignored second start with changing inputs
    t0 = tx_cnt; d0 = done_cnt; e0 = err_cnt;
    drive_start(CMD_CLEAR, LW'(31), rand_payload(), 1'b1);
    repeat (20) @(negedge sys_clk);
    drive_start(CMD_OUTER_PER, LW'(5), rand_payload(), 1'b0);
    bus.opcode = 8'hff; bus.len = LW'(7); bus.payload = rand_payload();
    wait_end("clamp", d0, e0, 2000);
    @(negedge sys_clk);
    frame_check("clamp", t0, d0, e0, 19, 1, 0);
    check("clamp_queue", 32'(exp_q.size()), 32'd0);

    // reset mid-frame, then a fresh frame carrying raw LF/CR payload bytes
    t0 = tx_cnt; d0 = done_cnt; e0 = err_cnt;
    drive_start(CMD_PRINT, LW'(4), rand_payload(), 1'b1);
    n = 0;
    while (tx_cnt - t0 < 2 && n < 300) begin @(negedge sys_clk); n++; end
    check("rst_reach_byte2", 32'(tx_cnt - t0), 32'd2);
    repeat (3) @(posedge sys_clk);
    #3 rst_n = 1'b0;
    #1 check_idle_outputs("rst_async");
    exp_q.delete();
    repeat (2) @(posedge sys_clk);
    #1 rst_n = 1'b1;
    repeat (20) @(negedge sys_clk);
    check("rst_no_end_pulse", 32'(done_cnt - d0 + err_cnt - e0), 32'd0);
    check("rst_no_more_tx", 32'(tx_cnt - t0), 32'd2);

    t0 = tx_cnt; d0 = done_cnt; e0 = err_cnt;
    pl = rand_payload();
    pl[7:0] = 8'h0a; pl[15:8] = 8'h0d;
    drive_start(CMD_PRINT, LW'(3), pl, 1'b1);
    wait_end("fresh", d0, e0, 600);
    @(negedge sys_clk);
    frame_check("fresh", t0, d0, e0, 6, 1, 0);

    repeat (5) @(negedge sys_clk);
    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/resp_framer.md
RESP_FRAMER -- requirements
Module: resp_framer

Interface
REQ-001 Parameter BYTES, default 16, maximum payload bytes per frame.
REQ-002 Parameter ACK_TIMEOUT, default 16, cycles allowed for the UART to raise is_transmitting after a transmit pulse.
REQ-003 sys_clk  input  1  single clock for all logic.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  one-cycle request to send a frame; sampled only in IDLE.
REQ-006 opcode  input  8  frame header byte, i.e. the command code being answered.
REQ-007 len  input  $clog2(BYTES+1)  payload byte count, 0..BYTES.
REQ-008 payload  input  8*BYTES  flat little-endian payload; byte k occupies [8k+7:8k].
REQ-009 is_transmitting  input  1  UART transmitter busy flag.
REQ-010 transmit  output  1  one-cycle pulse to the UART to send tx_byte.
REQ-011 tx_byte  output  8  byte presented to the UART.
REQ-012 busy  output  1  high from start acceptance until the done or err pulse.
REQ-013 done  output  1  one-cycle pulse after NL has finished shifting out.
REQ-014 err  output  1  one-cycle pulse when a frame is aborted on timeout.

Function
REQ-015 Frame byte order SHALL be: opcode, payload[0]..payload[len-1], CR (8'h0d), NL (8'h0a), giving len+3 bytes in total.
REQ-016 States SHALL be IDLE, SEND, WAIT_BUSY, WAIT_IDLE and FIN.
REQ-017 IDLE: on start=1, the block latches opcode, len and payload, sets busy=1 and moves to SEND on the next edge.
REQ-018 A len value greater than BYTES SHALL be clamped to BYTES when latched.
REQ-019 start in any state other than IDLE SHALL be ignored; latched data SHALL stay stable for the whole frame.
REQ-020 SEND: when is_transmitting=0, assert transmit for exactly one cycle with tx_byte = current byte, then go to WAIT_BUSY; while is_transmitting=1, remain in SEND.
REQ-021 WAIT_BUSY: on is_transmitting=1, go to WAIT_IDLE; the timeout counter increments each cycle otherwise.
REQ-022 Timeout: if the counter reaches ACK_TIMEOUT, pulse err, drop busy and return to IDLE with no further transmit.
REQ-023 WAIT_IDLE: on is_transmitting=0, advance the byte index; go to SEND if bytes remain, otherwise go to FIN.
REQ-024 FIN: pulse done for one cycle, drop busy in the same cycle and return to IDLE.
REQ-025 Latency: start at edge N yields transmit at edge N+2 when is_transmitting is low.
REQ-026 All outputs SHALL be registered; tx_byte holds its last value when idle.
REQ-027 When len=0, the frame SHALL be opcode, CR, NL.
REQ-028 Payload bytes equal to CR or NL SHALL be sent verbatim, with no escaping; the host avoids sending the CR,NL pair inside a payload.
REQ-029 done and err SHALL never be asserted in the same cycle.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE, transmit=0, tx_byte=0, busy=0, done=0, err=0, byte index=0 and timeout counter=0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame with no done or err pulse, and the remaining bytes are never sent.

Structure
REQ-032 The CR/NL constants, the command opcodes (STATE0=0, PER=1, ED=2, OUTER_PER=3, PRINT=4, CLEAR=5) and the state encoding SHALL live in a shared package that is also used by the command decoder.
REQ-033 The design SHALL be a single module with no sub-modules; the byte mux over payload is inline combinational logic.

Verification
REQ-034 UART model: is_transmitting rises 1 cycle after transmit and stays high for 10 cycles; opcode=8'h04, len=2, payload={8'hBE,8'hEF} -> tx_byte sequence 04,EF,BE,0D,0A, five transmit pulses, a single done, busy low afterwards.
REQ-035 len=0, opcode=8'h01 -> bytes 01,0D,0A, then done.
REQ-036 is_transmitting held high when start arrives -> no transmit until it falls; first transmit one edge after the fall.
REQ-037 UART model never raises is_transmitting -> err pulses 16 cycles after the first transmit, busy=0, no done.
REQ-038 Second start during a frame, plus len=31 clamped to 16 -> second start ignored; 19 bytes sent in total.
REQ-039 rst_n pulsed low after byte 2 -> outputs zero immediately, no done; a following start sends a complete fresh frame.
